// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter.
// Holds the requester count, default widths and the one-hot grant/owner type
// used by both the arbiter top and its grant sub-block.
package ram_arb_pkg;

    localparam int NUM_REQ       = 2;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MAX_BURST = 4;

    // One-hot per master; all-zero means "no grant" / "no owner".
    typedef logic [NUM_REQ-1:0] grant_t;

    localparam grant_t OWNER_NONE = '0;

    // Index of the set bit in a one-hot grant (meaningful only when non-zero).
    function automatic logic grant_idx(input grant_t g);
        return g[1];
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin grant with lock override.
// Ports:
//   valid    - per-master request valid
//   prio_ptr - preferred master when both request (0 or 1)
//   owner    - one-hot lock owner, OWNER_NONE when unlocked
//   burst_ok - owner has not yet used its full burst allowance
//   grant    - one-hot grant, at most one bit set
module rr_grant2
    import ram_arb_pkg::*;
(
    input  grant_t valid,
    input  logic   prio_ptr,
    input  grant_t owner,
    input  logic   burst_ok,
    output grant_t grant
);

    always_comb begin
        grant = OWNER_NONE;
        // owner is one-hot, so owner & valid is the owner's bit when it still asks
        if (burst_ok && ((owner & valid) != OWNER_NONE)) begin
            grant = owner & valid;
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_ptr ? 2'b10 : 2'b01;
                default: grant = OWNER_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-master round-robin arbiter in front of one single-port byte-enable RAM.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - per-master request handshake (ready = grant)
//   req_lock                 - master wants to keep the RAM next cycle
//   req_we/req_be/req_addr/req_wdata - packed per-master request fields
//   rsp_valid/rsp_rdata      - read response one cycle after a read grant
//   ram_we/ram_byte_en/ram_addr/ram_data_in - RAM control, driven only here
//   ram_data_out             - RAM registered read data
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*BE_W-1:0]     req_be,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        ram_we,
    output logic [BE_W-1:0]             ram_byte_en,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_data_in,
    input  logic [DATA_W-1:0]           ram_data_out
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    // Per-master views of the packed request buses
    logic [BE_W-1:0]   be_m    [NUM_REQ];
    logic [ADDR_W-1:0] addr_m  [NUM_REQ];
    logic [DATA_W-1:0] wdata_m [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign be_m[gi]    = req_be[gi*BE_W +: BE_W];
            assign addr_m[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_m[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic             prio_ptr_q,  prio_ptr_d;
    grant_t           owner_q,     owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    grant_t           rsp_tag_q,   rsp_tag_d;

    grant_t grant_raw;
    grant_t grant;
    logic   granted;
    logic   sel;
    logic   burst_ok;

    assign burst_ok = (burst_cnt_q < CNT_MAX);

    rr_grant2 u_grant (
        .valid    (req_valid),
        .prio_ptr (prio_ptr_q),
        .owner    (owner_q),
        .burst_ok (burst_ok),
        .grant    (grant_raw)
    );

    // No grants while reset is held, so nothing reaches the RAM or the tag.
    assign grant     = rst ? OWNER_NONE : grant_raw;
    assign granted   = (grant != OWNER_NONE);
    assign sel       = grant_idx(grant);
    assign req_ready = grant;

    // RAM control mux; idle value is a harmless read of address 0.
    always_comb begin
        ram_we      = 1'b0;
        ram_byte_en = '0;
        ram_addr    = '0;
        ram_data_in = '0;
        if (granted) begin
            ram_we      = req_we[sel];
            ram_byte_en = req_we[sel] ? be_m[sel] : '0;
            ram_addr    = addr_m[sel];
            ram_data_in = wdata_m[sel];
        end
    end

    // Response tag is registered; data is the RAM's own registered output.
    // Masking by rst drops a response that would land in a reset cycle.
    assign rsp_valid = rst ? '0 : rsp_tag_q;
    assign rsp_rdata = (rsp_valid != '0) ? ram_data_out : '0;

    always_comb begin
        prio_ptr_d  = prio_ptr_q;
        owner_d     = OWNER_NONE;
        burst_cnt_d = '0;
        rsp_tag_d   = OWNER_NONE;
        if (granted) begin
            prio_ptr_d = ~sel;
            rsp_tag_d  = req_we[sel] ? OWNER_NONE : grant;
            if (req_lock[sel]) begin
                owner_d = grant;
                if (owner_q == grant) begin
                    // Saturate: once exhausted the owner only wins uncontested
                    burst_cnt_d = burst_ok ? burst_cnt_q + CNT_W'(1) : burst_cnt_q;
                end else begin
                    burst_cnt_d = CNT_W'(1);
                end
            end
        end
        // Without a transfer nobody is requesting, so any lock is released.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr_q  <= 1'b0;
            owner_q     <= OWNER_NONE;
            burst_cnt_q <= '0;
            rsp_tag_q   <= OWNER_NONE;
        end else begin
            prio_ptr_q  <= prio_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

endmodule
